serial_insert_sorter: RTL and testbench
=======================================

Name: serial_insert_sorter

Overview:
Streaming, sequential ingress to the 4-line sorting network. The block accepts elements one per cycle over a valid/ready handshake and inserts each one into a sorted register bank (one insertion per cycle). It then presents the full sorted word on a valid/ready output with the same packing as the combinational sorter: the minimum sits in bits [W-1:0] and the maximum in the top slot. Upstream producers use it when data arrives serially instead of as a parallel 16-bit word.

Parameters:
W, 4, element width in bits
N, 4, elements per batch (slots); must be at least 2

Ports:
clk  input  1  clock; all state changes on the rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  producer offers in_data
in_ready  output  1  block can accept an element this cycle
in_data  input  W  element to insert
in_last  input  1  qualifies in_data as the final element of a short batch
out_valid  output  1  sorted batch available on o
out_ready  input  1  consumer takes the batch
o  output  N*W  sorted batch; slot k is o[W*k +: W]; ascending with k
out_count  output  clog2(N+1)  number of real elements in the batch (1..N)

Behaviour:
- Reset (rst=1 at an edge):
  - state goes to FILL; count goes to 0; all slots go to all-ones (2^W-1); out_valid goes to 0.
  - in_ready = (state==FILL) && !rst, so in_ready is 0 during the reset cycle and 1 from the first cycle after rst falls.
  - Reset mid-batch discards all held elements, with no partial output.
- States:
  - FILL: in_ready=1, out_valid=0.
  - FULL: in_ready=0, out_valid=1, and o and out_count are held stable.
- Accept condition is in_valid && in_ready.
- Insertion on accept, with x = in_data:
  - Each slot k computes next[k] = (slot[k] <= x) ? slot[k] : ((k==0 || slot[k-1] <= x) ? x : slot[k-1]).
  - The result is ascending order. Ties place x above existing equal values, but the outputs are data-only, so tie order is not observable.
- Count: count increments on each accept.
- FILL to FULL: the transition happens on an accept when count==N-1 or when in_last=1. out_count latches count+1.
- Latency: out_valid rises the cycle after the final accept. A full batch therefore takes N accept cycles plus 1.
- Short batch: slots that receive no element keep the all-ones pad and naturally sit in the top slots. Consumers use out_count to tell real values from padding; real values equal to 2^W-1 are legal.
- FULL to FILL: on out_valid && out_ready, slots reload all-ones, count goes to 0, and the state returns to FILL. The next accept can happen one cycle later. No simultaneous output handshake and input accept is possible.
- Backpressure: with out_ready=0 in FULL, the block holds indefinitely. o, out_count and out_valid stay unchanged.
- FILL inputs: in_last is ignored when in_valid=0. in_data is ignored unless the accept condition holds.
- o is driven from slot registers at all times. It is only meaningful while out_valid=1.

Decomposition:
- Package sort_pkg holds:
  - localparams W and N;
  - typedef elem_t = logic [W-1:0];
  - typedef enum {FILL, FULL} sort_state_t;
  - the pad constant ELEM_MAX = '1.
- Sub-module insert_slot: one comparator/mux cell.
  - Inputs: own value, lower-neighbour value, x, is_bottom.
  - Output: next value.
  - The top level instantiates N copies with a generate loop.

Test Plan:
- Full batch: accept 3,1,4,1 on consecutive cycles -> out_valid on the 5th cycle; o=16'h4311, out_count=4.
- Short batch: accept 9, then 2 with in_last=1 -> o=16'hFF92, out_count=2.
- Order extremes: inputs F,E,D,C -> o=16'hFEDC; inputs 0,1,2,3 -> o=16'h3210. Both have out_count=4.
- Backpressure: after batch 5,5,0,A, hold out_ready=0 for 5 cycles -> o=16'hA550 stable, in_ready=0, and in_valid pulses are not accepted. Raising out_ready -> in_ready=1 the next cycle, and the next batch 7,7,7,7 gives 16'h7777.
- Reset mid-batch: accept 8,6, then pulse rst -> out_valid=0, and in_ready=0 during the reset cycle and 1 after. Then accept 1,2,3,4 -> o=16'h4321 with no trace of 8 or 6.
- Gapped input: 2,0,1,3 with idle cycles (in_valid=0) between them -> o=16'h3210. out_valid rises exactly one cycle after the 4th accept.

Source files
------------

// File: rtl/sort_pkg.sv
// rtl/sort_pkg.sv - shared widths, element type, FSM states and pad constant for the serial insert sorter
package sort_pkg;

    localparam int W  = 4;
    localparam int N  = 4;
    localparam int CW = $clog2(N + 1);

    typedef logic [W-1:0] elem_t;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } sort_state_t;

    localparam elem_t ELEM_MAX = '1;

endpackage

// File: rtl/serial_insert_sorter_if.sv
// rtl/serial_insert_sorter_if.sv - element ingress and sorted-batch egress handshake bundle
interface serial_insert_sorter_if;
    import sort_pkg::*;

    logic              in_valid;
    logic              in_ready;
    elem_t             in_data;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [N*W-1:0]    o;
    logic [CW-1:0]     out_count;

    modport master (
        output in_valid,
        input  in_ready,
        output in_data,
        output in_last,
        input  out_valid,
        output out_ready,
        input  o,
        input  out_count
    );

    modport slave (
        input  in_valid,
        output in_ready,
        input  in_data,
        input  in_last,
        output out_valid,
        input  out_ready,
        output o,
        output out_count
    );

endinterface

// File: rtl/insert_slot.sv
// rtl/insert_slot.sv - one compare/shift cell of the sorted register bank
module insert_slot
    import sort_pkg::*;
(
    input  elem_t own,
    input  elem_t lower,
    input  elem_t x,
    input  logic  is_bottom,
    output elem_t nxt
);

    // Keep own value if it is not above x; otherwise take x if it lands here, else shift the lower neighbour up
    always_comb begin
        nxt = own;
        if (own > x) begin
            if (is_bottom || (lower <= x)) begin
                nxt = x;
            end else begin
                nxt = lower;
            end
        end
    end

endmodule

// File: rtl/serial_insert_sorter.sv
// rtl/serial_insert_sorter.sv - serial ingress that insertion-sorts elements into a bank and emits the sorted batch
module serial_insert_sorter
    import sort_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    serial_insert_sorter_if.slave bus
);

    sort_state_t    state;
    elem_t          slots [N];
    elem_t          nxt   [N];
    logic [CW-1:0]  count;
    logic [CW-1:0]  out_count_q;
    logic           out_valid_q;
    logic           in_ready;
    logic           accept;
    logic [N*W-1:0] o_flat;

    assign in_ready = (state == FILL) && !rst;
    assign accept   = bus.in_valid && in_ready;

    // One comparator/mux cell per slot; slot 0 has no lower neighbour
    for (genvar k = 0; k < N; k++) begin : g_slot
        if (k == 0) begin : g_bot
            insert_slot u_cell (
                .own       (slots[k]),
                .lower     (ELEM_MAX),
                .x         (bus.in_data),
                .is_bottom (1'b1),
                .nxt       (nxt[k])
            );
        end else begin : g_up
            insert_slot u_cell (
                .own       (slots[k]),
                .lower     (slots[k-1]),
                .x         (bus.in_data),
                .is_bottom (1'b0),
                .nxt       (nxt[k])
            );
        end
    end

    // Pack the bank with the minimum in the low slot
    always_comb begin
        o_flat = '0;
        for (int k = 0; k < N; k++) begin
            o_flat[W*k +: W] = slots[k];
        end
    end

    // FILL/FULL controller: insert on accept, close the batch on the Nth or last element, reload on output handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FILL;
            count       <= '0;
            out_valid_q <= 1'b0;
            out_count_q <= '0;
            for (int k = 0; k < N; k++) begin
                slots[k] <= ELEM_MAX;
            end
        end else begin
            case (state)
                FILL: begin
                    if (accept) begin
                        for (int k = 0; k < N; k++) begin
                            slots[k] <= nxt[k];
                        end
                        count <= count + CW'(1);
                        if ((count == CW'(N - 1)) || bus.in_last) begin
                            state       <= FULL;
                            out_valid_q <= 1'b1;
                            out_count_q <= count + CW'(1);
                        end
                    end
                end
                FULL: begin
                    if (bus.out_ready) begin
                        state       <= FILL;
                        count       <= '0;
                        out_valid_q <= 1'b0;
                        for (int k = 0; k < N; k++) begin
                            slots[k] <= ELEM_MAX;
                        end
                    end
                end
                default: begin
                    state <= FILL;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_count = out_count_q;
    assign bus.o         = o_flat;

endmodule

// File: tb/tb_serial_insert_sorter.sv
// tb/tb_serial_insert_sorter.sv - randomized and directed self-checking bench for serial_insert_sorter
module tb_serial_insert_sorter;
    import sort_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    serial_insert_sorter_if bus ();

    serial_insert_sorter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Sorted batch word: accepted values ascending, unfilled slots padded with all-ones
    function automatic logic [N*W-1:0] sorted_word(input int q[$]);
        int a [N];
        int t;
        logic [N*W-1:0] r;
        for (int i = 0; i < N; i++) a[i] = (1 << W) - 1;
        for (int i = 0; i < q.size(); i++) a[i] = q[i];
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N - 1 - i; j++)
                if (a[j] > a[j+1]) begin
                    t = a[j]; a[j] = a[j+1]; a[j+1] = t;
                end
        r = '0;
        for (int k = 0; k < N; k++) r[W*k +: W] = a[k][W-1:0];
        return r;
    endfunction

    int             m_items[$];
    bit             m_full = 1'b0;
    logic [N*W-1:0] m_o    = '0;
    int             m_cnt  = 0;
    bit             cmp_en = 1'b0;

    // Reference model: a list of accepted elements and a "batch ready" flag
    always @(posedge clk) begin
        if (rst) begin
            m_items.delete();
            m_full = 1'b0;
        end else if (!m_full) begin
            if (bus.in_valid) begin
                m_items.push_back(int'(bus.in_data));
                if (m_items.size() == N || bus.in_last) begin
                    m_full = 1'b1;
                    m_o    = sorted_word(m_items);
                    m_cnt  = m_items.size();
                end
            end
        end else if (bus.out_ready) begin
            m_full = 1'b0;
            m_items.delete();
        end
        cmp_en = 1'b1;
    end

    // Compare DUT against the model every cycle, mid-cycle
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("in_ready", bus.in_ready, !m_full && !rst);
            chk("out_valid", bus.out_valid, m_full);
            if (m_full) begin
                chk("o", bus.o, m_o);
                chk("out_count", bus.out_count, m_cnt);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int d, input bit last);
        bit ok;
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = d[W-1:0];
        bus.in_last  = last;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (bus.in_ready) ok = 1'b1;
        end
        if (!ok) begin
            errors++;
            checks++;
            $display("FAIL send_timeout: in_ready stayed 0 for data %0h", d);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic recv(input string name, input logic [N*W-1:0] exp_o, input int exp_cnt);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (bus.out_valid) ok = 1'b1;
        end
        if (!ok) begin
            errors++;
            checks++;
            $display("FAIL %s_timeout: out_valid never rose", name);
        end else begin
            chk({name, "_o"}, bus.o, exp_o);
            chk({name, "_cnt"}, bus.out_count, exp_cnt);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        rst           = 1'b1;
        idle(2);
        @(negedge clk);
        chk("reset_in_ready", bus.in_ready, 1'b0);
        chk("reset_out_valid", bus.out_valid, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_in_ready", bus.in_ready, 1'b1);
        @(posedge clk);
        #1;

        send(3, 0); send(1, 0); send(4, 0); send(1, 0);
        recv("full_batch", 16'h4311, 4);

        send(9, 0); send(2, 1);
        recv("short_batch", 16'hFF92, 2);

        send(15, 0); send(14, 0); send(13, 0); send(12, 0);
        recv("descending", 16'hFEDC, 4);
        send(0, 0); send(1, 0); send(2, 0); send(3, 0);
        recv("ascending", 16'h3210, 4);

        send(5, 0); send(5, 0); send(0, 0); send(10, 0);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = elem_t'($urandom_range(0, 15));
            @(negedge clk);
            chk("bp_o", bus.o, 16'hA550);
            chk("bp_in_ready", bus.in_ready, 1'b0);
            chk("bp_out_valid", bus.out_valid, 1'b1);
            @(posedge clk);
            #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("bp_release_in_ready", bus.in_ready, 1'b1);
        @(posedge clk);
        #1;
        send(7, 0); send(7, 0); send(7, 0); send(7, 0);
        recv("sevens", 16'h7777, 4);

        send(8, 0); send(6, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", bus.in_ready, 1'b0);
        chk("midrst_out_valid", bus.out_valid, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_after_in_ready", bus.in_ready, 1'b1);
        @(posedge clk);
        #1;
        send(1, 0); send(2, 0); send(3, 0); send(4, 0);
        recv("after_reset", 16'h4321, 4);

        send(2, 0); idle(2);
        send(0, 0); idle(1);
        send(1, 0); idle(3);
        send(3, 0);
        @(negedge clk);
        chk("gap_latency", bus.out_valid, 1'b1);
        @(posedge clk);
        #1;
        recv("gapped", 16'h3210, 4);

        for (int c = 0; c < 3000; c++) begin
            bus.in_valid  = ($urandom % 3) != 0;
            bus.in_data   = elem_t'($urandom_range(0, 15));
            bus.in_last   = ($urandom % 6) == 0;
            bus.out_ready = ($urandom % 3) == 0;
            rst           = ($urandom % 200) == 0;
            @(posedge clk);
            #1;
        end
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        rst           = 1'b0;
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
